psec6_readout_seq: RTL
======================

PSEC6_READOUT_SEQ -- requirements
Module: psec6_readout_seq

Interface
REQ-001 Parameter: NUM_CH, default 8, number of channel digital blocks served (1..8).
REQ-002 Parameter: NUM_REG, default 6, registers per channel (0 = trigger_cnt, 1..5 = CA..CE).
REQ-003 Clock and reset: one clock, SPI_CLK; reset is asynchronous and active-high, named RST.
REQ-004 SPI_CLK  in  1  40 MHz readout clock, shared with channel readout shifters.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 READOUT_REQ  in  1  one-cycle start pulse from SPI command decoder.
REQ-007 CH_MASK  in  NUM_CH  channel enable, sampled on accepted READOUT_REQ.
REQ-008 CNT_SER  in  NUM_CH  serial data from each channel, MSB first.
REQ-009 INST_READOUT  out  NUM_CH  one-hot channel readout enable.
REQ-010 SELECT_REG  out  3  register select, common to all channels.
REQ-011 DATA_WORD  out  16  {ch[2:0], reg[2:0], data[9:0]}.
REQ-012 DATA_VALID  out  1  DATA_WORD valid.
REQ-013 DATA_READY  in  1  downstream SPI transmitter accepts word.
REQ-014 BUSY  out  1  high from accepted request until DONE.
REQ-015 DONE  out  1  one-cycle pulse at end of sequence.

Function
REQ-016 States: IDLE, LOAD, SHIFT, OUT, DONE; all transitions on SPI_CLK rising edge.
REQ-017 IDLE: READOUT_REQ=1 latches CH_MASK into mask_q, sets ch=lowest enabled channel, reg=0, goes to LOAD; BUSY=1 next cycle.
REQ-018 IDLE with READOUT_REQ and CH_MASK all zero: go directly to DONE; no word emitted.
REQ-019 READOUT_REQ outside IDLE ignored; CH_MASK changes after acceptance have no effect.
REQ-020 LOAD: one cycle; INST_READOUT[ch]=1, SELECT_REG=reg; then SHIFT with bit counter=0.
REQ-021 SHIFT: exactly 10 cycles; INST_READOUT[ch] and SELECT_REG held; CNT_SER[ch] sampled each rising edge into data shifter, MSB first.
REQ-022 reg 0: data[9:3] forced to zero in DATA_WORD; data[2:0] = last three sampled bits.
REQ-023 After 10th sample: INST_READOUT all zero, DATA_WORD loaded, DATA_VALID=1, state OUT.
REQ-024 OUT: DATA_WORD and DATA_VALID held stable while DATA_READY=0; no further shifting (stall).
REQ-025 OUT with DATA_READY=1: transfer occurs that edge; DATA_VALID drops next cycle unless immediately reloaded (never in this design; minimum one-cycle gap via LOAD).
REQ-026 After transfer: reg<NUM_REG-1 -> reg+1, LOAD; else next enabled channel above ch, reg=0, LOAD; none remaining -> DONE.
REQ-027 DONE: DONE=1 one cycle, BUSY=0 from following cycle, return to IDLE.
REQ-028 INST_READOUT never has more than one bit set; zero in IDLE, OUT, DONE.
REQ-029 Per word: 1 LOAD + 10 SHIFT + ≥1 OUT cycles; full 8-channel sequence with DATA_READY tied high = 48 words x 12 = 576 cycles plus DONE.
REQ-030 Disabled channels never receive INST_READOUT; channel index in DATA_WORD is physical index.

Reset
REQ-031 RST asserted: state IDLE, all outputs 0 (INST_READOUT, SELECT_REG, DATA_WORD, DATA_VALID, BUSY, DONE) immediately, independent of SPI_CLK.
REQ-032 RST mid-sequence: sequence aborted, no DONE pulse, partial word discarded; new READOUT_REQ after deassertion restarts from lowest enabled channel, reg 0.
REQ-033 RST deassertion takes effect on first SPI_CLK edge after release; READOUT_REQ on that edge accepted.

Verification
REQ-034 CH_MASK=8'h01, ch0 model shifts trigger_cnt=3'b101 then CA..CE=10'h3FF,10'h000,10'h155,10'h2AA,10'h001, DATA_READY=1 -> words 16'h0005,16'h07FF,16'h0800,16'h0D55,16'h12AA,16'h1401, then DONE, 72 cycles after request.
REQ-035 CH_MASK=8'h84 -> INST_READOUT only on bits 2 then 7; words carry ch=2 then ch=7; 12 words.
REQ-036 DATA_READY held 0 for 20 cycles during first OUT -> DATA_WORD/DATA_VALID stable 20 cycles, INST_READOUT stays 0, sequence resumes with no lost or duplicated word.
REQ-037 CH_MASK=0 with READOUT_REQ -> DONE pulse within 2 cycles, DATA_VALID never asserted.
REQ-038 RST pulse during SHIFT of ch3 reg2 -> all outputs 0 asynchronously, no DONE; subsequent request with 8'h08 yields 6 fresh words starting reg 0.
REQ-039 READOUT_REQ pulsed while BUSY -> ignored, word count unchanged, exactly one DONE.

Source files
------------

// File: rtl/psec6_readout_seq.sv
`timescale 1ns/1ps
// psec6_readout_seq: walks the enabled channel digital blocks, shifts out each
// channel's trigger counter and CA..CE registers serially, and presents each
// result as a 16-bit {ch, reg, data} word with a valid/ready handshake.
module psec6_readout_seq #(
  parameter int NUM_CH  = 8,
  parameter int NUM_REG = 6
) (
  input  logic              SPI_CLK,
  input  logic              RST,
  input  logic              READOUT_REQ,
  input  logic [NUM_CH-1:0] CH_MASK,
  input  logic [NUM_CH-1:0] CNT_SER,
  output logic [NUM_CH-1:0] INST_READOUT,
  output logic [2:0]        SELECT_REG,
  output logic [15:0]       DATA_WORD,
  output logic              DATA_VALID,
  input  logic              DATA_READY,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_OUT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [2:0]        ch_q, ch_d;
  logic [2:0]        reg_q, reg_d;
  logic [3:0]        bit_q, bit_d;
  logic [8:0]        shift_q, shift_d;
  logic [15:0]       word_q, word_d;

  logic [2:0]        first_ch;
  logic              first_any;
  logic [2:0]        next_ch;
  logic              next_any;
  logic              last_reg;
  logic              ser_bit;
  logic [9:0]        sampled;

  assign last_reg = (int'(reg_q) >= NUM_REG - 1);
  assign ser_bit  = CNT_SER[ch_q];
  assign sampled  = {shift_q, ser_bit};

  // Lowest enabled channel of the incoming request mask
  always_comb begin
    first_ch  = '0;
    first_any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (CH_MASK[i]) begin
        first_ch  = 3'(i);
        first_any = 1'b1;
      end
    end
  end

  // Next enabled channel strictly above the current one in the latched mask
  always_comb begin
    next_ch  = '0;
    next_any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        next_ch  = 3'(i);
        next_any = 1'b1;
      end
    end
  end

  // State register; reset aborts any sequence in flight without a DONE pulse
  always_ff @(posedge SPI_CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one LOAD, ten SHIFT, OUT until accepted, then advance
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (READOUT_REQ) state_d = first_any ? S_LOAD : S_DONE;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (bit_q == 4'd9) state_d = S_OUT;
      S_OUT:   if (DATA_READY) state_d = (!last_reg || next_any) ? S_LOAD : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencing registers: latched mask, channel/register position, shifter, output word
  always_comb begin
    mask_d  = mask_q;
    ch_d    = ch_q;
    reg_d   = reg_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (READOUT_REQ) begin
          mask_d = CH_MASK;
          ch_d   = first_ch;
          reg_d  = '0;
        end
      end
      S_LOAD: bit_d = '0;
      S_SHIFT: begin
        shift_d = sampled[8:0];
        bit_d   = bit_q + 4'd1;
        // trigger_cnt is only 3 bits wide; its upper bits are not meaningful
        if (bit_q == 4'd9)
          word_d = {ch_q, reg_q, (reg_q == 3'd0) ? {7'd0, sampled[2:0]} : sampled};
      end
      S_OUT: begin
        if (DATA_READY) begin
          if (!last_reg) begin
            reg_d = reg_q + 3'd1;
          end else begin
            reg_d = '0;
            ch_d  = next_ch;
          end
        end
      end
      default: ;
    endcase
  end

  // Register update for the sequencing state
  always_ff @(posedge SPI_CLK or posedge RST) begin
    if (RST) begin
      mask_q  <= '0;
      ch_q    <= '0;
      reg_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
    end else begin
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      reg_q   <= reg_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      word_q  <= word_d;
    end
  end

  // Outputs decoded from the state; channel enable only while loading/shifting
  always_comb begin
    INST_READOUT = '0;
    SELECT_REG   = '0;
    if (state_q == S_LOAD || state_q == S_SHIFT) begin
      INST_READOUT[ch_q] = 1'b1;
      SELECT_REG         = reg_q;
    end
    DATA_WORD  = word_q;
    DATA_VALID = (state_q == S_OUT);
    BUSY       = (state_q != S_IDLE);
    DONE       = (state_q == S_DONE);
  end

endmodule
